fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 123 ++++++++++++
 tb/tb_fifo_sync_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Optional first-word-fall-through output selected by defining FIFO_FWFT_EN.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic AF_RST = (AF_LEVEL <= 0) ? 1'b1 : 1'b0;
  localparam logic AE_RST = (AE_LEVEL >= 0) ? 1'b1 : 1'b0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [CW-1:0]         w_count_next;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    w_rd_ok      = rd_en & ~r_empty;
    w_wr_ok      = wr_en & (~r_full | w_rd_ok);
    w_count_next = r_count + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_rd_ok};
  end

  // Pointers, count, flags and sticky errors; every flag derives from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= {AW{1'b0}};
      r_rd_ptr       <= {AW{1'b0}};
      r_count        <= {CW{1'b0}};
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= AF_RST;
      r_almost_empty <= AE_RST;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count        <= w_count_next;
      r_full         <= (w_count_next == CW'(DEPTH));
      r_empty        <= (w_count_next == {CW{1'b0}});
      r_almost_full  <= (w_count_next >= CW'(AF_LEVEL));
      r_almost_empty <= (w_count_next <= CW'(AE_LEVEL));
      // A new error in the same cycle as err_clr keeps the flag set.
      r_overflow     <= (wr_en & ~w_wr_ok) | (r_overflow  & ~err_clr);
      r_underflow    <= (rd_en & ~w_rd_ok) | (r_underflow & ~err_clr);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is presented directly; zero while nothing is stored.
  assign data_out = r_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_data_out;

  // Registered read port: one cycle latency, holds between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= {DATA_WIDTH{1'b0}};
    end else if (w_rd_ok) begin
      r_data_out <= r_mem[r_rd_ptr];
    end else begin
      r_data_out <= r_data_out;
    end
  end

  assign data_out = r_data_out;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: queue-based reference model, directed and random stimulus.
module tb_fifo_sync_param;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, sticky errors, last value read out.
  int mq[$];
  int exp_q[$];
  bit m_ovf = 0;
  bit m_udf = 0;
  int m_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_last = 0;
  endtask

  task automatic check_status(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"}, int'(count), n);
    chk({tag, ":full"}, int'(full), int'(n == DEPTH));
    chk({tag, ":empty"}, int'(empty), int'(n == 0));
    chk({tag, ":almost_full"}, int'(almost_full), int'(n >= AF));
    chk({tag, ":almost_empty"}, int'(almost_empty), int'(n <= AE));
    chk({tag, ":overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ":underflow"}, int'(underflow), int'(m_udf));
`ifdef FIFO_FWFT_EN
    chk({tag, ":data_out_head"}, int'(data_out), (n > 0) ? mq[0] : 0);
`else
    chk({tag, ":data_out_hold"}, int'(data_out), m_last);
`endif
  endtask

  // One clock cycle: drive, advance the model, then check status after the edge.
  task automatic cycle(input bit wr, input bit rd, input int din, input bit clr, input string tag);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din[DW-1:0];
    err_clr = clr;
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      m_last = mq.pop_front();
      exp_q.push_back(m_last);
    end
    if (wr_ok) mq.push_back(din & 'hFF);
    m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
    m_udf = (rd && !rd_ok) || (m_udf && !clr);
    @(posedge clk);
    #1;
    check_status(tag);
  endtask

  // Monitor: a handshake (rd_en with data available) yields one scoreboard entry.
  always @(posedge clk) begin
    bit fire;
    int e;
    fire = rst_n && rd_en && !empty;
`ifdef FIFO_FWFT_EN
    if (fire) begin
      if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_read_data", int'(data_out), e);
      end
    end
`else
    #1;
    if (fire) begin
      if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_read_data", int'(data_out), e);
      end
    end
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) cycle(1, 0, i, 0, "fill");
    cycle(1, 0, 'hFF, 0, "overflow_write");
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, "drain");
    cycle(0, 1, 0, 0, "underflow_read");
    cycle(0, 0, 0, 1, "err_clr1");

    for (int i = 0; i < 8; i++) cycle(1, 0, $urandom_range(0, 255), 0, "load");
    cycle(1, 1, 'hAA, 0, "rw_at_full");
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, "drain_aa");
    chk("aa_last", m_last, 'hAA);

    cycle(1, 1, 'h55, 0, "rw_at_empty");
    cycle(0, 1, 0, 0, "read_55");

    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, i, 0, "wrap_wr");
      cycle(0, 1, 0, 0, "wrap_rd");
    end
    cycle(0, 0, 0, 1, "err_clr2");

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
            $urandom_range(0, 255), ($urandom_range(0, 99) < 5), "random");
    end

    while (mq.size() > 0) cycle(0, 1, 0, 0, "flush");
    for (int i = 0; i < 5; i++) cycle(1, 0, 'h10 + i, 0, "pre_reset");
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_status("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 0, 'h3C, 0, "write_3c");
    cycle(0, 0, 0, 0, "idle_3c");
    cycle(0, 1, 0, 0, "read_3c");
    cycle(0, 0, 0, 0, "idle_end");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
